// File: rtl/pc_sequencer.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// pc_sequencer
//
// Fetch controller for the program counter register. It requests an
// instruction at the current PC, hands it to decode with a valid/ready
// handshake, then picks the next PC from the trap, jump, branch or sequential
// sources. It also supports halt/resume and counts retired instructions.
//
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   pc_in           current PC register value
//   pc_next         next PC value for the PC register (combinational)
//   pc_enable       PC register load enable (combinational)
//   imem_req        instruction fetch request, address on imem_addr
//   imem_ack        fetch complete
//   instr_valid     instruction available to decode
//   decode_ready    decode accepts the instruction
//   branch_taken    conditional branch taken, destination branch_target
//   jump            unconditional jump, destination jump_target
//   trap            level-sensitive trap request
//   halt, resume    enter HALT after retiring / leave HALT
//   misalign        one-cycle pulse after a misaligned redirect target
//   retired_count   completed handshakes, wraps
//   state           FETCH=0, ISSUE=1, HALT=2
// ---------------------------------------------------------------------------
module pc_sequencer #(
  parameter int unsigned        BITSIZE     = 32,
  parameter int unsigned        STEP        = 4,
  parameter logic [BITSIZE-1:0] TRAP_VECTOR = 32'h0000_0080
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [BITSIZE-1:0] pc_in,
  output logic [BITSIZE-1:0] pc_next,
  output logic               pc_enable,
  output logic               imem_req,
  output logic [BITSIZE-1:0] imem_addr,
  input  logic               imem_ack,
  output logic               instr_valid,
  input  logic               decode_ready,
  input  logic               branch_taken,
  input  logic [BITSIZE-1:0] branch_target,
  input  logic               jump,
  input  logic [BITSIZE-1:0] jump_target,
  input  logic               trap,
  input  logic               halt,
  input  logic               resume,
  output logic               misalign,
  output logic [BITSIZE-1:0] retired_count,
  output logic [1:0]         state
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    ISSUE = 2'd1,
    HALT  = 2'd2
  } state_t;

  // STEP is a power of two, so STEP-1 masks the bits that must be zero.
  localparam logic [BITSIZE-1:0] ALIGN_MASK = BITSIZE'(STEP - 1);
  localparam logic [BITSIZE-1:0] STEP_INC   = BITSIZE'(STEP);

  state_t             cur_state;
  logic               trap_pending;
  logic               misalign_q;
  logic [BITSIZE-1:0] retired_q;

  logic               trap_any;
  logic               handshake;
  logic               halt_trap;
  logic               redirect;
  logic [BITSIZE-1:0] redirect_target;
  logic               target_misaligned;
  logic [BITSIZE-1:0] issue_pc;

  // Next-PC selection. A pending trap outranks everything, then jump, then
  // branch. A misaligned jump/branch target is replaced by the trap vector;
  // the misalign flag is only raised when that target actually got selected.
  always_comb begin
    trap_any          = trap | trap_pending;
    handshake         = (cur_state == ISSUE) & decode_ready;
    halt_trap         = (cur_state == HALT) & trap_any;
    redirect          = jump | branch_taken;
    redirect_target   = jump ? jump_target : branch_target;
    target_misaligned = redirect & (|(redirect_target & ALIGN_MASK));
    issue_pc          = pc_in + STEP_INC;
    if (trap_any) begin
      issue_pc = TRAP_VECTOR;
    end else if (target_misaligned) begin
      issue_pc = TRAP_VECTOR;
    end else if (redirect) begin
      issue_pc = redirect_target;
    end
  end

  // Outputs seen by the PC register and memory. Reset gates the requests
  // immediately so an in-flight fetch request drops in the reset cycle.
  always_comb begin
    pc_enable = 1'b0;
    pc_next   = pc_in;
    if (reset) begin
      pc_next = '0;
    end else begin
      pc_enable = handshake | halt_trap;
      if (cur_state == HALT) begin
        pc_next = halt_trap ? TRAP_VECTOR : pc_in;
      end else begin
        pc_next = issue_pc;
      end
    end
  end

  assign imem_req      = ~reset & (cur_state == FETCH);
  assign imem_addr     = pc_in;
  assign instr_valid   = ~reset & (cur_state == ISSUE);
  assign misalign      = ~reset & misalign_q;
  assign retired_count = retired_q;
  assign state         = cur_state;

  // Sequencer FSM plus its bookkeeping: retire counter, deferred trap and the
  // misalign pulse. A trap seen while an instruction is still in flight is
  // remembered and applied at the next handshake (or on the way out of HALT).
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_state    <= FETCH;
      trap_pending <= 1'b0;
      misalign_q   <= 1'b0;
      retired_q    <= '0;
    end else begin
      misalign_q <= handshake & ~trap_any & target_misaligned;
      case (cur_state)
        FETCH: begin
          if (trap) begin
            trap_pending <= 1'b1;
          end
          if (imem_ack) begin
            cur_state <= ISSUE;
          end
        end
        ISSUE: begin
          if (decode_ready) begin
            retired_q    <= retired_q + 1'b1;
            trap_pending <= 1'b0;
            cur_state    <= halt ? HALT : FETCH;
          end else if (trap) begin
            trap_pending <= 1'b1;
          end
        end
        HALT: begin
          if (trap_any) begin
            trap_pending <= 1'b0;
            cur_state    <= FETCH;
          end else if (resume) begin
            cur_state <= FETCH;
          end
        end
        default: begin
          cur_state <= FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_pc_sequencer
//
// Drives pc_sequencer together with a behavioural PC register. Inputs change
// on the falling edge; a reference model stepped once per cycle predicts the
// outputs, and directed sequences pin a set of hand-computed values.
// ---------------------------------------------------------------------------
module tb_pc_sequencer;

  localparam logic [31:0] Z    = 32'd0;
  localparam logic [31:0] TVEC = 32'h0000_0080;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc_reg;
  logic [31:0] pc_next;
  logic        pc_enable;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic        instr_valid;
  logic        decode_ready = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic        jump = 1'b0;
  logic [31:0] jump_target = '0;
  logic        trap = 1'b0;
  logic        halt = 1'b0;
  logic        resume = 1'b0;
  logic        misalign;
  logic [31:0] retired_count;
  logic [1:0]  state;

  int assertions = 0;
  int failures   = 0;

  pc_sequencer #(.BITSIZE(32), .STEP(4), .TRAP_VECTOR(32'h0000_0080)) dut (
    .clk          (clk),
    .reset        (reset),
    .pc_in        (pc_reg),
    .pc_next      (pc_next),
    .pc_enable    (pc_enable),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .instr_valid  (instr_valid),
    .decode_ready (decode_ready),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .jump         (jump),
    .jump_target  (jump_target),
    .trap         (trap),
    .halt         (halt),
    .resume       (resume),
    .misalign     (misalign),
    .retired_count(retired_count),
    .state        (state)
  );

  always #5 clk = ~clk;

  // The PC register the sequencer controls.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_reg <= '0;
    end else if (pc_enable) begin
      pc_reg <= pc_next;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertions++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  // One cycle of stimulus, applied at the falling edge; returns shortly after
  // so the caller can look at this cycle's outputs before the rising edge.
  task automatic applyStimulus(input logic r, input logic ack, input logic rdy,
                               input logic trp, input logic hlt, input logic res,
                               input logic jmp, input logic [31:0] jt,
                               input logic br, input logic [31:0] bt);
    @(negedge clk);
    reset = r; imem_ack = ack; decode_ready = rdy;
    trap = trp; halt = hlt; resume = res;
    jump = jmp; jump_target = jt;
    branch_taken = br; branch_target = bt;
    #3;
  endtask

  // Reference rule for choosing the next PC at a handshake or trap exit.
  function automatic logic [31:0] choose_pc(input logic [31:0] pc, input bit t,
                                            input bit j, input logic [31:0] jt,
                                            input bit b, input logic [31:0] bt,
                                            output bit bad);
    logic [31:0] tgt;
    bad = 1'b0;
    if (t) return TVEC;
    if (!j && !b) return pc + 32'd4;
    tgt = j ? jt : bt;
    if (tgt % 4 != 0) begin
      bad = 1'b1;
      return TVEC;
    end
    return tgt;
  endfunction

  // Model: phase 0 waits for memory, 1 offers the instruction, 2 is halted.
  int          m_phase = 0;
  bit          m_pend = 1'b0;
  bit          m_mis = 1'b0;
  logic [31:0] m_pc = '0;
  logic [31:0] m_ret = '0;
  bit          model_on = 1'b0;

  // Compare process: checks every cycle once the model is synchronised,
  // then advances the model across the coming rising edge.
  always @(negedge clk) begin
    bit          hs, htrap, en, bad;
    logic [31:0] npc;
    #2;
    hs    = !reset && m_phase == 1 && decode_ready;
    htrap = !reset && m_phase == 2 && (trap || m_pend);
    en    = hs || htrap;
    npc   = choose_pc(m_pc, trap || m_pend || htrap, jump, jump_target,
                      branch_taken, branch_target, bad);
    if (model_on) begin
      checkOutput("state", {30'd0, state}, m_phase);
      checkOutput("retired_count", retired_count, m_ret);
      checkOutput("pc_in", pc_reg, m_pc);
      checkOutput("imem_req", {31'd0, imem_req}, {31'd0, !reset && m_phase == 0});
      if (!reset && m_phase == 0) checkOutput("imem_addr", imem_addr, m_pc);
      checkOutput("instr_valid", {31'd0, instr_valid}, {31'd0, !reset && m_phase == 1});
      checkOutput("pc_enable", {31'd0, pc_enable}, {31'd0, en});
      if (reset) checkOutput("pc_next_reset", pc_next, Z);
      else if (en) checkOutput("pc_next", pc_next, npc);
      checkOutput("misalign", {31'd0, misalign}, {31'd0, !reset && m_mis});
    end
    if (reset) begin
      m_phase = 0; m_pend = 0; m_mis = 0; m_pc = '0; m_ret = '0;
      model_on = 1'b1;
    end else begin
      case (m_phase)
        0: if (imem_ack) m_phase = 1;
        1: if (decode_ready) m_phase = halt ? 2 : 0;
        default: if (htrap || resume) m_phase = 0;
      endcase
      if (trap && !hs && !htrap && !en && (hs || !(hs)) && (m_phase == m_phase)) begin end
      if (en) m_pc = npc;
      if (hs) m_ret = m_ret + 32'd1;
      m_mis = hs && bad;
      if (en) m_pend = 1'b0;
      else if (trap && !htrap && !(hs) && (!reset)) m_pend = m_pend || (trap && (hs == 1'b0) && (htrap == 1'b0));
    end
  end

  function automatic logic rnd(input int pct);
    return $urandom_range(0, 99) < pct;
  endfunction

  function automatic logic [31:0] rtarget();
    logic [31:0] t;
    t = $urandom & 32'hFFFF_FFFC;
    if ($urandom_range(0, 5) == 0) t[1:0] = 2'($urandom_range(1, 3));
    return t;
  endfunction

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset state.
    applyStimulus(1, 0, 0, 0, 0, 0, 0, Z, 0, Z);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, Z, 0, Z);
    checkOutput("reset_state", {30'd0, state}, Z);
    checkOutput("reset_retired", retired_count, Z);
    checkOutput("reset_req", {31'd0, imem_req}, Z);
    checkOutput("reset_pc_next", pc_next, Z);

    // Sequential flow, ack two cycles after each request.
    for (int k = 0; k < 4; k++) begin
      applyStimulus(0, 0, 1, 0, 0, 0, 0, Z, 0, Z);
      checkOutput("seq_req", {31'd0, imem_req}, 32'd1);
      checkOutput("seq_addr", imem_addr, 32'(4 * k));
      checkOutput("seq_no_enable_fetch", {31'd0, pc_enable}, Z);
      applyStimulus(0, 0, 1, 0, 0, 0, 0, Z, 0, Z);
      applyStimulus(0, 1, 1, 0, 0, 0, 0, Z, 0, Z);
      applyStimulus(0, 0, 1, 0, 0, 0, 0, Z, 0, Z);
      checkOutput("seq_enable", {31'd0, pc_enable}, 32'd1);
      checkOutput("seq_pc_next", pc_next, 32'(4 * k + 4));
    end
    applyStimulus(0, 0, 1, 0, 0, 0, 0, Z, 0, Z);
    checkOutput("seq_retired", retired_count, 32'd4);
    checkOutput("seq_addr_after", imem_addr, 32'd16);

    // Backpressure for three cycles.
    applyStimulus(0, 1, 0, 0, 0, 0, 0, Z, 0, Z);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0, Z, 0, Z);
      checkOutput("bp_valid", {31'd0, instr_valid}, 32'd1);
      checkOutput("bp_enable", {31'd0, pc_enable}, Z);
      checkOutput("bp_pc", pc_reg, 32'd16);
    end
    applyStimulus(0, 0, 1, 0, 0, 0, 0, Z, 0, Z);
    checkOutput("bp_release", pc_next, 32'd20);

    // Move to 0x10, then jump and branch together, then with a trap as well.
    applyStimulus(0, 1, 0, 0, 0, 0, 0, Z, 0, Z);
    applyStimulus(0, 0, 1, 0, 0, 0, 1, 32'h10, 0, Z);
    applyStimulus(0, 1, 0, 0, 0, 0, 0, Z, 0, Z);
    checkOutput("prio_addr", imem_addr, 32'h10);
    applyStimulus(0, 0, 1, 0, 0, 0, 1, 32'h40, 1, 32'h20);
    checkOutput("prio_jump", pc_next, 32'h40);
    applyStimulus(0, 1, 0, 0, 0, 0, 0, Z, 0, Z);
    applyStimulus(0, 0, 1, 1, 0, 0, 1, 32'h40, 1, 32'h20);
    checkOutput("prio_trap", pc_next, 32'h80);

    // Misaligned branch target.
    applyStimulus(0, 1, 0, 0, 0, 0, 0, Z, 0, Z);
    applyStimulus(0, 0, 1, 0, 0, 0, 0, Z, 1, 32'h22);
    checkOutput("mis_pc_next", pc_next, 32'h80);
    checkOutput("mis_not_yet", {31'd0, misalign}, Z);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, Z, 0, Z);
    checkOutput("mis_pulse", {31'd0, misalign}, 32'd1);
    checkOutput("mis_fetch", imem_addr, 32'h80);
    applyStimulus(0, 1, 0, 0, 0, 0, 0, Z, 0, Z);
    checkOutput("mis_pulse_end", {31'd0, misalign}, Z);

    // Halt at a handshake, stay halted, resume.
    applyStimulus(0, 0, 1, 0, 1, 0, 0, Z, 0, Z);
    checkOutput("halt_pc_next", pc_next, 32'h84);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(0, 1, 1, 0, 0, 0, 0, Z, 0, Z);
      checkOutput("halt_state", {30'd0, state}, 32'd2);
      checkOutput("halt_no_req", {31'd0, imem_req}, Z);
    end
    applyStimulus(0, 0, 0, 0, 0, 1, 0, Z, 0, Z);
    checkOutput("resume_no_enable", {31'd0, pc_enable}, Z);
    applyStimulus(0, 1, 0, 0, 0, 0, 0, Z, 0, Z);
    checkOutput("resume_state", {30'd0, state}, Z);
    checkOutput("resume_addr", imem_addr, 32'h84);

    // Halt again, then trap together with resume.
    applyStimulus(0, 0, 1, 0, 1, 0, 0, Z, 0, Z);
    applyStimulus(0, 0, 0, 1, 0, 1, 0, Z, 0, Z);
    checkOutput("halt_trap_enable", {31'd0, pc_enable}, 32'd1);
    checkOutput("halt_trap_pc", pc_next, 32'h80);
    applyStimulus(0, 1, 0, 0, 0, 0, 0, Z, 0, Z);
    checkOutput("halt_trap_fetch", imem_addr, 32'h80);

    // Sequential wrap from the top of the address space.
    applyStimulus(0, 0, 1, 0, 0, 0, 1, 32'hFFFF_FFFC, 0, Z);
    applyStimulus(0, 1, 0, 0, 0, 0, 0, Z, 0, Z);
    checkOutput("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    applyStimulus(0, 0, 1, 0, 0, 0, 0, Z, 0, Z);
    checkOutput("wrap_pc_next", pc_next, Z);

    // Trap pulse during the fetch wait is applied at the next handshake.
    applyStimulus(0, 0, 0, 1, 0, 0, 0, Z, 0, Z);
    checkOutput("defer_no_enable", {31'd0, pc_enable}, Z);
    applyStimulus(0, 1, 0, 0, 0, 0, 0, Z, 0, Z);
    applyStimulus(0, 0, 1, 0, 0, 0, 0, Z, 0, Z);
    checkOutput("defer_pc_next", pc_next, 32'h80);

    // Reset in the middle of a fetch.
    applyStimulus(0, 0, 0, 0, 0, 0, 0, Z, 0, Z);
    checkOutput("midreset_req_before", {31'd0, imem_req}, 32'd1);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, Z, 0, Z);
    checkOutput("midreset_req", {31'd0, imem_req}, Z);
    applyStimulus(1, 1, 0, 0, 0, 0, 0, Z, 0, Z);
    checkOutput("midreset_retired", retired_count, Z);

    // Randomised traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(rnd(1), rnd(50), rnd(60), rnd(5), rnd(10), rnd(20),
                    rnd(15), rtarget(), rnd(20), rtarget());
    end

    @(negedge clk);
    #4;
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
